// File: rtl/ws2812_chain.sv
// WS2812 chain driver: indexed pixel buffer, frame streamer with latch time, on-board LED register.
// Optional: define WS2812_AUTOSTART_EN to start a frame when the last pixel is committed.
module ws2812_chain #(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned CLK_FRE  = 25_175_000,
   parameter int unsigned T0H      = (CLK_FRE / 1_000_000) * 40 / 100,
   parameter int unsigned T1H      = (CLK_FRE / 1_000_000) * 85 / 100,
   parameter int unsigned T0L      = T1H,
   parameter int unsigned T1L      = T0H,
   parameter int unsigned TRST     = (CLK_FRE / 1_000_000) * 80
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       R_W_n,
   input  logic [2:0] reg_addr_i,
   input  logic [7:0] data_i,
   input  logic       led_cs,
   output logic [7:0] data_o,
   output logic [7:0] leds,
   output logic       ws2812
);

   localparam int unsigned IW   = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_LEDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;

   state_t        r_state, w_next;
   logic [23:0]   r_buf [NUM_LEDS];
   logic [IW-1:0] r_index, r_pix;
   logic [7:0]    r_r, r_g, r_b, r_leds;
   logic          r_pending, r_busy, r_ws;
   logic [23:0]   r_shift;
   logic [4:0]    r_bit;
   logic [31:0]   r_cnt;

   logic          w_wr, w_commit, w_in_range, w_req;
   logic [31:0]   w_len;
   logic          w_cnt_end, w_start, w_load, w_next_bit, w_next_pix, w_done, w_high;

   assign w_wr       = led_cs & ~R_W_n;
   assign w_commit   = w_wr && (reg_addr_i == 3'd3);
   assign w_in_range = 32'(r_index) < NUM_LEDS;
`ifdef WS2812_AUTOSTART_EN
   assign w_req = (w_wr && (reg_addr_i == 3'd4) && data_i[0]) || (w_commit && (r_index == LAST));
`else
   assign w_req = w_wr && (reg_addr_i == 3'd4) && data_i[0];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_index <= '0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_leds  <= '0;
      end else if (w_wr) begin
         case (reg_addr_i)
            3'd0: r_index <= data_i[IW-1:0];
            3'd1: r_r     <= data_i;
            3'd2: r_g     <= data_i;
            3'd3: begin
               r_b     <= data_i;
               r_index <= (r_index == LAST) ? '0 : r_index + IW'(1);
            end
            3'd5: r_leds  <= data_i;
            default: ;
         endcase
      end
   end

   // Buffer has no reset; a same-edge LOAD of this entry still sees the old value.
   always_ff @(posedge clk_i) begin
      if (w_commit && w_in_range) r_buf[r_index] <= {r_g, r_r, data_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_pending) w_next = S_LOAD;
         S_LOAD:  w_next = S_HIGH;
         S_HIGH:  if (w_cnt_end) w_next = S_LOW;
         S_LOW:   if (w_cnt_end) w_next = (r_bit != 5'd0) ? S_HIGH :
                                          (r_pix != LAST) ? S_LOAD : S_LATCH;
         S_LATCH: if (w_cnt_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_len = '0;
      case (r_state)
         S_HIGH:  w_len = r_shift[23] ? T1H : T0H;
         S_LOW:   w_len = r_shift[23] ? T1L : T0L;
         S_LATCH: w_len = TRST;
         default: ;
      endcase
      w_cnt_end  = (w_len != '0) && (r_cnt == w_len - 32'd1);
      w_start    = (r_state == S_IDLE) && r_pending;
      w_load     = (r_state == S_LOAD);
      w_high     = (r_state == S_HIGH);
      w_next_bit = (r_state == S_LOW) && w_cnt_end && (r_bit != 5'd0);
      w_next_pix = (r_state == S_LOW) && w_cnt_end && (r_bit == 5'd0) && (r_pix != LAST);
      w_done     = (r_state == S_LATCH) && w_cnt_end;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pending <= 1'b0;
         r_busy    <= 1'b0;
         r_pix     <= '0;
         r_shift   <= '0;
         r_bit     <= '0;
         r_cnt     <= '0;
         r_ws      <= 1'b0;
      end else begin
         r_ws      <= w_high;
         // A new request on the same edge IDLE consumes the old one must survive.
         r_pending <= w_req | (r_pending & ~w_start);
         if (w_start) begin
            r_busy <= 1'b1;
            r_pix  <= '0;
         end else if (w_done) begin
            r_busy <= 1'b0;
         end
         if (w_next_pix) r_pix <= r_pix + IW'(1);
         if (w_load) begin
            r_shift <= r_buf[r_pix];
            r_bit   <= 5'd23;
         end else if (w_next_bit) begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_bit   <= r_bit - 5'd1;
         end
         r_cnt <= (w_cnt_end || (r_state == S_IDLE) || (r_state == S_LOAD)) ? '0 : r_cnt + 32'd1;
      end
   end

   always_comb begin
      data_o = '0;
      case (reg_addr_i)
         3'd0: data_o = 8'(r_index);
         3'd1: data_o = r_r;
         3'd2: data_o = r_g;
         3'd3: data_o = r_b;
         3'd4: data_o = {6'b0, r_pending, r_busy};
         3'd5: data_o = r_leds;
         default: ;
      endcase
   end

   assign leds   = r_leds;
   assign ws2812 = r_ws;

endmodule

// File: tb/tb_ws2812_chain.sv
// Scoreboard bench for ws2812_chain (NUM_LEDS=4): pulse widths and register reads checked against a model.
module tb_ws2812_chain;

   localparam int unsigned N    = 4;
   localparam int unsigned T0H  = 10;
   localparam int unsigned T1H  = 21;
   localparam int unsigned T0L  = 21;
   localparam int unsigned T1L  = 10;
   localparam int unsigned TRST = 2000;

   logic       clk = 1'b0;
   logic       rst, R_W_n, led_cs;
   logic [2:0] addr;
   logic [7:0] din, dout, leds;
   logic       ws;

   always #5 clk = ~clk;

   ws2812_chain #(.NUM_LEDS(N)) dut (
      .clk_i(clk), .rst_i(rst), .R_W_n(R_W_n), .reg_addr_i(addr), .data_i(din),
      .led_cs(led_cs), .data_o(dout), .leds(leds), .ws2812(ws)
   );

   typedef struct { int unsigned hi; int unsigned lo; } bit_t;

   bit_t        sb_q[$];
   logic [7:0]  rd_q[$];
   int unsigned n_checks = 0, n_errors = 0;
   bit          mon_flush = 1'b0, rd_req = 1'b0;
   int unsigned n_rises = 0;

   logic [23:0] m_buf [N];
   int unsigned m_index;
   logic [7:0]  m_r, m_g, m_b, m_leds;
   bit          m_busy, m_followup;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void push_frame();
      bit_t rec;
      logic bv;
      for (int p = 0; p < N; p++) begin
         for (int b = 23; b >= 0; b--) begin
            bv     = m_buf[p][b];
            rec.hi = bv ? T1H : T0H;
            rec.lo = bv ? T1L : T0L;
            if (b == 0) rec.lo = (p == N - 1) ? 0 : rec.lo + 1;
            sb_q.push_back(rec);
         end
      end
   endfunction

   function automatic void request();
      bit_t t;
      if (!m_busy) begin
         m_busy = 1'b1;
         push_frame();
      end else if (!m_followup) begin
         m_followup = 1'b1;
         if (sb_q.size() > 0) begin
            t    = sb_q[sb_q.size() - 1];
            t.lo = ((t.hi == T1H) ? T1L : T0L) + TRST + 2;
            sb_q[sb_q.size() - 1] = t;
         end
         push_frame();
      end
   endfunction

   function automatic void model_write(input logic [2:0] a, input logic [7:0] d);
      case (a)
         3'd0: m_index = d % 4;
         3'd1: m_r = d;
         3'd2: m_g = d;
         3'd3: begin
            m_b = d;
            m_buf[m_index] = {m_g, m_r, d};
`ifdef WS2812_AUTOSTART_EN
            if (m_index == N - 1) request();
`endif
            m_index = (m_index + 1) % N;
         end
         3'd4: if (d[0]) request();
         3'd5: m_leds = d;
         default: ;
      endcase
   endfunction

   function automatic logic [7:0] exp_reg(input logic [2:0] a);
      case (a)
         3'd0: return 8'(m_index);
         3'd1: return m_r;
         3'd2: return m_g;
         3'd3: return m_b;
         3'd4: return {6'b0, m_followup, m_busy};
         3'd5: return m_leds;
         default: return 8'h00;
      endcase
   endfunction

   function automatic void model_reset();
      m_index = 0; m_r = '0; m_g = '0; m_b = '0; m_leds = '0;
      m_busy = 1'b0; m_followup = 1'b0;
   endfunction

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      led_cs = 1'b1; R_W_n = 1'b0; addr = a; din = d;
      model_write(a, d);
      @(negedge clk);
      led_cs = 1'b0; R_W_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a);
      @(negedge clk);
      addr = a; R_W_n = 1'b1; led_cs = 1'b1;
      rd_q.push_back(exp_reg(a));
      rd_req = 1'b1;
      @(posedge clk);
      rd_req = 1'b0; led_cs = 1'b0;
   endtask

   task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      wr(3'd1, r); wr(3'd2, g); wr(3'd3, b);
   endtask

   task automatic rand_pixels();
      for (int i = 0; i < N; i++) pix(8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic wait_high();
      int unsigned k = 0;
      while (ws !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (ws !== 1'b1) chk("frame_start_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int unsigned k = 0;
      while (sb_q.size() != 0 && k < 40000) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) begin
         chk("frame_timeout_bits_left", sb_q.size(), 0);
         sb_q.delete();
      end
      repeat (TRST + 100) @(negedge clk);
      m_busy = 1'b0;
      m_followup = 1'b0;
   endtask

   // Pulse monitor: counts high/low run lengths and pops one expected bit per falling edge.
   int unsigned hi_run = 0, lo_run = 0, held_lo = 0;
   logic        prev_ws = 1'b0;
   bit_t        mrec;
   always @(negedge clk) begin
      if (mon_flush || rst) begin
         hi_run = 0; lo_run = 0; held_lo = 0; prev_ws = 1'b0;
      end else begin
         if (ws === 1'b1 && prev_ws == 1'b0) begin
            n_rises++;
            if (held_lo != 0) chk("low_width", lo_run, held_lo);
            held_lo = 0;
            hi_run  = 1;
         end else if (ws === 1'b1) begin
            hi_run++;
         end else if (prev_ws == 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pulse: got high pulse of %0d cycles, expected none", hi_run);
            end else begin
               mrec = sb_q.pop_front();
               chk("high_width", hi_run, mrec.hi);
               held_lo = mrec.lo;
            end
            lo_run = 1;
         end else begin
            lo_run++;
         end
         prev_ws = ws;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rd_req) begin
         if (rd_q.size() == 0) chk("read_queue_empty", 0, 1);
         else chk($sformatf("read_reg%0d", addr), dout, rd_q.pop_front());
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k, base;
      logic [2:0]  a;
      logic [7:0]  d;
      rst = 1'b1; R_W_n = 1'b1; led_cs = 1'b0; addr = '0; din = '0;
      model_reset();
      repeat (5) begin
         @(negedge clk);
         chk("reset_ws2812", ws, 0);
         chk("reset_leds", leds, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Directed frame
      wr(3'd0, 8'd0);
      pix(8'h01, 8'h80, 8'h00);
      pix(8'h00, 8'h00, 8'hFF);
      pix(8'h00, 8'h00, 8'h00);
      pix(8'h00, 8'h00, 8'h00);
      wr(3'd4, 8'h01);
`ifndef WS2812_AUTOSTART_EN
      k = 0;
      while (ws !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("request_to_rise_cycles", k, 3);
`endif
      wait_idle();
      rd(3'd4);
      chk("idle_ws2812_low", ws, 0);

      // Repeated requests during a frame merge into one follow-up
      rand_pixels();
      wr(3'd4, 8'h01);
      wait_high();
      wr(3'd4, 8'h01);
      wr(3'd4, 8'h01);
      rd(3'd4);
      wait_idle();
      rd(3'd4);

      // Five commits wrap INDEX; pixel 0 is overwritten
      wr(3'd0, 8'd0);
      for (int i = 0; i < 5; i++) pix(8'($urandom), 8'($urandom), 8'($urandom));
      rd(3'd0);
      wr(3'd4, 8'h01);
      wait_idle();

      // Random register traffic while idle
      for (int i = 0; i < 40; i++) begin
         a = 3'($urandom_range(0, 7));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            if (a == 3'd3 || a == 3'd4) a = 3'd5;
            wr(a, d);
         end else begin
            rd(a);
         end
      end
      chk("leds_port", leds, m_leds);

      // Random frame
      wr(3'd0, 8'd0);
      rand_pixels();
      wr(3'd4, 8'h01);
      wait_idle();

      // Reset in the middle of a high phase
      wr(3'd0, 8'd0);
      rand_pixels();
      wr(3'd4, 8'h01);
      wait_high();
      mon_flush = 1'b1;
      rst = 1'b1;
      #1;
      chk("async_reset_ws2812", ws, 0);
      sb_q.delete();
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mon_flush = 1'b0;
      base = n_rises;
      repeat (2500) @(negedge clk);
      chk("pulses_after_reset", n_rises - base, 0);
      rd(3'd4);
      rd(3'd0);
      rd(3'd5);

      // Commit to the last index
      wr(3'd0, 8'd3);
      base = n_rises;
      pix(8'($urandom), 8'($urandom), 8'($urandom));
`ifdef WS2812_AUTOSTART_EN
      wait_high();
      wait_idle();
      chk("autostart_frame_seen", (n_rises - base) > 0 ? 1 : 0, 1);
`else
      repeat (3000) @(negedge clk);
      chk("no_autostart_pulses", n_rises - base, 0);
`endif
      rd(3'd0);
      rd(3'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ws2812_chain.md
# ws2812_chain

Parametrised WS2812 chain driver for the nano6502 IO page, successor to the single-pixel LED core. Holds a pixel buffer of NUM_LEDS GRB entries written through an indexed register window. On request it streams the whole chain on one data line and then holds the mandatory latch (reset) low time. It also keeps the eight on-board LEDs register so it can replace the older core on the same chip select.

## Interface
- NUM_LEDS, 8: pixels in chain; legal 1..256; index width IW = max(1, clog2(NUM_LEDS)).
- CLK_FRE, 25_175_000: clock frequency in Hz.
- T0H, (CLK_FRE/1_000_000)*40/100: cycles high for a 0 bit (10 at default).
- T1H, (CLK_FRE/1_000_000)*85/100: cycles high for a 1 bit (21).
- T0L, T1H: cycles low for a 0 bit (21).
- T1L, T0H: cycles low for a 1 bit (10).
- TRST, (CLK_FRE/1_000_000)*80: latch low cycles after a frame (2000).
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- R_W_n  in  1  1 = read, 0 = write.
- reg_addr_i  in  3  register select.
- data_i  in  8  write data.
- led_cs  in  1  chip select; a write happens on every clk_i edge where led_cs=1 and R_W_n=0.
- data_o  out  8  combinational read data.
- leds  out  8  on-board LED register.
- ws2812  out  1  serial data to the chain (registered).

## Operation
- Register map:
  - 0 INDEX: R/W; low IW bits are used; reads return the index zero-extended.
  - 1 R, 2 G, 3 B: R/W staging bytes.
  - 4 CTRL: write bit0=1 requests a frame. Read returns {6'b0, pending, busy}.
  - 5 LEDS: R/W on-board LEDs.
  - 6–7: reads return 0; writes are ignored.
- Writing B stores {G,R,data_i} into buffer[INDEX] and increments INDEX. INDEX wraps from NUM_LEDS-1 to 0. Writing INDEX ≥ NUM_LEDS stores INDEX mod 2^IW, and a B commit at an out-of-range index is dropped but still increments and wraps INDEX.
- The buffer is not reset. Staging registers, INDEX, leds, pending and busy reset to 0.
- Transmit FSM:
  - IDLE: ws2812=0. If pending=1, clear pending, set busy, set pix=0, go to LOAD.
  - LOAD: shift register ← buffer[pix] as G[7:0],R[7:0],B[7:0], MSB first; bit=23; go to HIGH.
  - HIGH: ws2812=1 for T1H or T0H cycles depending on the current bit, then go to LOW.
  - LOW: ws2812=0 for T1L or T0L cycles. Then:
    - if bit>0: bit−1, go to HIGH;
    - else if pix<NUM_LEDS−1: pix+1, go to LOAD;
    - else go to LATCH.
  - LATCH: ws2812=0 for TRST cycles, then clear busy and go to IDLE.
- A frame request sets pending regardless of busy. A request during a frame queues exactly one follow-up frame; repeated requests merge into it.
- Buffer writes during a frame are allowed. Each pixel is sampled at its LOAD.
- If a commit and a LOAD hit the same entry in the same cycle, LOAD gets the old value.

## Timing
- Reset values: ws2812=0, leds=0. data_o follows reg_addr_i combinationally (INDEX=0 after reset).
- A CTRL write at edge N sets pending at N. IDLE sees it at N+1, and ws2812 rises at N+3 (IDLE→LOAD→HIGH, registered output).
- The LOAD cycle adds one low cycle before each pixel's first bit, within WS2812 tolerance.
- Each bit lasts exactly T?H+T?L cycles. LATCH holds ws2812 low for exactly TRST cycles, and busy falls on the cycle the FSM enters IDLE.
- Frame length is NUM_LEDS·(1 + Σbit periods) + TRST + 2 cycles.
- When rst_i asserts mid-frame, the FSM goes to IDLE and ws2812 drops to 0 immediately. The pending request is lost.

## Configuration
- WS2812_AUTOSTART_EN defined: a B commit to index NUM_LEDS−1 also sets pending, in the same cycle as the commit.
- Not defined: frames start only through CTRL bit0.

## Test plan
- Reset, then read every register → 0. ws2812=0 and leds=0 throughout.
- NUM_LEDS=4: write INDEX=0, then pixels (R,G,B) = (0x01,0x80,0x00), (0,0,0xFF), 0, 0, then CTRL=1. Decode the ws2812 pulse widths:
  - the 96 bits are G=0x80,R=0x01,B=0x00 / 0,0,0xFF / zeros;
  - high times are 21 cycles for a 1 bit and 10 for a 0 bit;
  - 2000 low cycles follow, then busy=0.
- Write CTRL=1 twice during a frame → pending=1 is read. Exactly two frames are sent back to back with a latch between them.
- Commit 5 pixels with NUM_LEDS=4 → INDEX reads 1. buffer[0] holds the fifth pixel.
- Assert rst_i mid-bit (ws2812 high) → ws2812=0 the same cycle. busy=0, and no further pulses occur.
- With WS2812_AUTOSTART_EN: committing index 3 starts a frame with no CTRL write. Without the macro, no pulses occur.
